// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin pipelined arbiter slice.
//   W_DEF / DEPTH_DEF : default data width and pipeline depth
//   LAST_RST          : reset value of the "last granted" marker. It points at
//                       port 1, so port 0 wins the first contention.
//   beat_t            : one tagged beat {src, data}
//   rr_grant()        : 2-way round-robin grant, returns {g1, g0}
// -----------------------------------------------------------------------------
package rr_arb_pkg;

  localparam int   W_DEF     = 8;
  localparam int   DEPTH_DEF = 2;
  localparam logic LAST_RST  = 1'b1;

  typedef struct packed {
    logic             src;
    logic [W_DEF-1:0] data;
  } beat_t;

  // When both ports request, grant the port that was not served last.
  function automatic logic [1:0] rr_grant(input logic v_0, input logic v_1, input logic last);
    logic [1:0] g;
    case ({v_1, v_0})
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Purely combinational 2-way round-robin grant.
// Ports:
//   i_v_0, i_v_1 : request valids
//   i_last       : port that received the most recent accepted grant
//   o_g0, o_g1   : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2
  import rr_arb_pkg::*;
(
  input  logic i_v_0,
  input  logic i_v_1,
  input  logic i_last,
  output logic o_g0,
  output logic o_g1
);

  logic [1:0] w_grant;

  // Grant decode from the two requests and the last-served marker.
  always_comb begin
    w_grant = rr_grant(i_v_0, i_v_1, i_last);
    o_g0    = w_grant[0];
    o_g1    = w_grant[1];
  end

endmodule

// File: rtl/rr_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pipe_arbiter
// Two requesters share one registered delay pipeline through a round-robin
// arbiter. Each accepted beat is tagged with its source port and leaves the
// last stage DEPTH cycles later. The pipe holds as a whole while the
// downstream stalls.
//
// Ports:
//   clk          clock, all state on posedge
//   rst_n        synchronous active-low reset
//   w_0/v_0      requester 0 data / valid;  rdy_0 requester 0 ready
//   w_1/v_1      requester 1 data / valid;  rdy_1 requester 1 ready
//   w_o/v_o      output data / valid (last stage);  rdy_o downstream ready
//   src_o        source tag of w_o
//   cnt_0/cnt_1  per-port grant counters
//
// Configuration macro: ARB_CNT_EN
//   defined   -> cnt_0/cnt_1 count accepted transfers per port, wrapping at 255
//   undefined -> cnt_0/cnt_1 are tied to zero and no counter flops exist
// -----------------------------------------------------------------------------
module rr_pipe_arbiter
  import rr_arb_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] w_0,
  input  logic         v_0,
  output logic         rdy_0,
  input  logic [W-1:0] w_1,
  input  logic         v_1,
  output logic         rdy_1,
  output logic [W-1:0] w_o,
  output logic         v_o,
  input  logic         rdy_o,
  output logic         src_o,
  output logic [7:0]   cnt_0,
  output logic [7:0]   cnt_1
);

  logic [W-1:0] r_dat [DEPTH];
  logic         r_src [DEPTH];
  logic         r_vld [DEPTH];
  logic         r_last;

  logic         w_g0;
  logic         w_g1;
  logic         w_adv;
  logic         w_xfer_0;
  logic         w_xfer_1;
  logic         w_xfer;
  logic         w_sel_src;
  logic [W-1:0] w_sel_dat;

  rr_arb2 u_arb (
    .i_v_0  (v_0),
    .i_v_1  (v_1),
    .i_last (r_last),
    .o_g0   (w_g0),
    .o_g1   (w_g1)
  );

  // Advance and handshake logic. Readiness is gated by reset so nothing is
  // accepted while the pipe is being cleared.
  always_comb begin
    w_adv     = ~r_vld[DEPTH-1] | rdy_o;
    rdy_0     = w_g0 & w_adv & rst_n;
    rdy_1     = w_g1 & w_adv & rst_n;
    w_xfer_0  = v_0 & rdy_0;
    w_xfer_1  = v_1 & rdy_1;
    w_xfer    = w_xfer_0 | w_xfer_1;
    w_sel_src = w_xfer_1;
    w_sel_dat = w_xfer_1 ? w_1 : w_0;
  end

  // Pipeline stages and last-served marker. The whole pipe shifts together,
  // so bubbles are carried along rather than collapsed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_src[i] <= 1'b0;
        r_dat[i] <= {W{1'b0}};
      end
      r_last <= LAST_RST;
    end else if (w_adv) begin
      r_vld[0] <= w_xfer;
      if (w_xfer) begin
        r_src[0] <= w_sel_src;
        r_dat[0] <= w_sel_dat;
        r_last   <= w_sel_src;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_src[i] <= r_src[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign v_o   = r_vld[DEPTH-1];
  assign w_o   = r_dat[DEPTH-1];
  assign src_o = r_src[DEPTH-1];

`ifdef ARB_CNT_EN
  logic [7:0] r_cnt_0;
  logic [7:0] r_cnt_1;

  // Per-port grant counters. They count accepted transfers only, so a
  // downstream stall, which blocks acceptance, never moves them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_0 <= 8'd0;
      r_cnt_1 <= 8'd0;
    end else begin
      if (w_xfer_0) begin
        r_cnt_0 <= r_cnt_0 + 8'd1;
      end
      if (w_xfer_1) begin
        r_cnt_1 <= r_cnt_1 + 8'd1;
      end
    end
  end

  assign cnt_0 = r_cnt_0;
  assign cnt_1 = r_cnt_1;
`else
  assign cnt_0 = 8'd0;
  assign cnt_1 = 8'd0;
`endif

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_pipe_arbiter
// Scoreboard bench for rr_pipe_arbiter. The stimulus process predicts
// handshakes from a queue model of the pipe: the pipe is a fixed-length
// delay line that advances only when the output is free. Each beat it
// predicts as accepted is pushed into a scoreboard queue. A separate monitor
// pops that queue whenever the DUT completes an output transfer. The monitor
// also checks that the output holds steady during a stall.
// Honours ARB_CNT_EN for counter expectations.
// -----------------------------------------------------------------------------
module tb_rr_pipe_arbiter;
  import rr_arb_pkg::*;

  localparam int W     = W_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] w_0, w_1, w_o;
  logic         v_0, v_1, rdy_0, rdy_1, v_o, rdy_o, src_o;
  logic [7:0]   cnt_0, cnt_1;

  always #5 clk = ~clk;

  rr_pipe_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .w_0   (w_0),
    .v_0   (v_0),
    .rdy_0 (rdy_0),
    .w_1   (w_1),
    .v_1   (v_1),
    .rdy_1 (rdy_1),
    .w_o   (w_o),
    .v_o   (v_o),
    .rdy_o (rdy_o),
    .src_o (src_o),
    .cnt_0 (cnt_0),
    .cnt_1 (cnt_1)
  );

  typedef struct {
    logic  vld;
    beat_t b;
  } slot_t;

  slot_t      m_pipe[$];
  beat_t      sb[$];
  logic       m_last;
  int         m_cnt0, m_cnt1;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] d0, d1;
  logic       pend0, pend1;
  bit         rand_data;
  bit         mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int c);
`ifdef ARB_CNT_EN
    return 8'(c);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    slot_t s;
    s.vld = 1'b0;
    s.b   = '0;
    m_pipe.delete();
    for (int i = 0; i < DEPTH; i++) m_pipe.push_back(s);
    m_last = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // One clock cycle: drive, check handshake prediction, update model.
  task automatic step(input logic nv0, input logic nv1, input logic nrdy, input logic nrst);
    logic  exp_vo, adv, pick1, e0, e1;
    slot_t s;
    @(negedge clk);
    v_0   = nv0;
    v_1   = nv1;
    w_0   = d0;
    w_1   = d1;
    rdy_o = nrdy;
    rst_n = nrst;
    #1;
    exp_vo = m_pipe[0].vld;
    adv    = !exp_vo || nrdy;
    pick1  = nv1 && (!nv0 || !m_last);
    e1     = nrst && adv && pick1;
    e0     = nrst && adv && nv0 && !pick1;
    chk("rdy_0", {31'd0, rdy_0}, {31'd0, e0});
    chk("rdy_1", {31'd0, rdy_1}, {31'd0, e1});
    chk("v_o", {31'd0, v_o}, {31'd0, exp_vo});
    chk("cnt_0", {24'd0, cnt_0}, {24'd0, exp_cnt(m_cnt0)});
    chk("cnt_1", {24'd0, cnt_1}, {24'd0, exp_cnt(m_cnt1)});
    if (!nrst) begin
      // A beat presented now with rdy_o high still leaves the pipe.
      if (exp_vo && nrdy) begin
        while (sb.size() > 1) void'(sb.pop_back());
      end else begin
        sb.delete();
      end
      model_reset();
    end else begin
      if (adv) begin
        m_pipe.delete(0);
        s.vld    = e0 || e1;
        s.b.src  = e1;
        s.b.data = e1 ? d1 : d0;
        m_pipe.push_back(s);
        if (s.vld) begin
          sb.push_back(s.b);
          m_last = e1;
        end
      end
      if (e0) begin
        m_cnt0++;
        d0 = rand_data ? 8'($urandom) : d0 + 8'd1;
      end
      if (e1) begin
        m_cnt1++;
        d1 = rand_data ? 8'($urandom) : d1 + 8'd1;
      end
    end
    pend0 = nv0 && !e0;
    pend1 = nv1 && !e1;
  endtask

  // Monitor: output transfers against the scoreboard, stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_w;
  logic       prev_src;
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (prev_stall) begin
          chk("stall_v", {31'd0, v_o}, 32'd1);
          chk("stall_w", {24'd0, w_o}, {24'd0, prev_w});
          chk("stall_src", {31'd0, src_o}, {31'd0, prev_src});
        end
        if (v_o === 1'b1 && rdy_o === 1'b1) begin
          if (sb.size() == 0) begin
            chk("sb_empty_on_output", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            chk("out_data", {24'd0, w_o}, {24'd0, e.data});
            chk("out_src", {31'd0, src_o}, {31'd0, e.src});
          end
        end
        prev_stall = (v_o === 1'b1) && (rdy_o === 1'b0) && (rst_n === 1'b1);
        prev_w     = w_o;
        prev_src   = src_o;
      end
    end
  end

  initial begin
    logic a0, a1, r;
    rst_n = 1'b0; v_0 = 1'b0; v_1 = 1'b0; w_0 = 8'd0; w_1 = 8'd0; rdy_o = 1'b1;
    d0 = 8'd0; d1 = 8'd0; pend0 = 1'b0; pend1 = 1'b0; rand_data = 1'b0; mon_en = 1'b0;
    model_reset();
    @(posedge clk);
    mon_en = 1'b1;

    // 1: reset with both requesting
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // 2: single port, latency DEPTH
    d0 = 8'hA5;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);

    // 3: contention after reset, port 0 first
    step(1'b0, 1'b0, 1'b1, 1'b0);
    d0 = 8'h10; d1 = 8'h20;
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);

    // 4: fill, stall 3 cycles, release
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1);

    // 5: reset with two beats in flight, then contention grants port 0
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with requester hold protocol
    rand_data = 1'b1;
    repeat (500) begin
      a0 = pend0 ? 1'b1 : 1'($urandom_range(0, 1));
      a1 = pend1 ? 1'b1 : 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      step(a0, a1, r, 1'b1);
    end
    repeat (DEPTH + 2) step(1'b0, 1'b0, 1'b1, 1'b1);

    // 6: 300 port-0 transfers -> counter wraps to 44
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (300) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef ARB_CNT_EN
    chk("cnt0_wrap", {24'd0, cnt_0}, 32'd44);
`else
    chk("cnt0_off", {24'd0, cnt_0}, 32'd0);
`endif
    chk("cnt1_idle", {24'd0, cnt_1}, 32'd0);
    repeat (DEPTH + 2) step(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
